// File: rtl/top_soc_module.sv
// Purpose : Fixed-function classifier. It scores each of 32 stored images
//           against 10 weight vectors, keeps the argmax class of every image
//           in a small result file, and shows one result on the LEDs. The
//           LEDs show a result only in access mode 2'b01 and only once every
//           image has been classified.
// Ports   : clk      - system clock, rising edge
//           rst      - asynchronous active-high reset
//           pipeline - 1: whole dot product per cycle, 0: one feature MAC per cycle
//                      (sampled when leaving IDLE)
//           switches - [6:5] access mode, [4:0] image index
//           leds     - registered class ID, or 7'h0F when locked
//           done     - registered, high once all images are classified
//
// state  | meaning
// IDLE   | first cycle after reset; latch engine mode, clear counters
// RUN    | score classes of r_img, then write its argmax (r_wr cycle)
// FINISH | all 32 results stored; terminal until reset
module top_soc_module (
   input  logic       clk,
   input  logic       rst,
   input  logic       pipeline,
   input  logic [6:0] switches,
   output logic [6:0] leds,
   output logic       done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

   state_t             r_state, w_state_nxt;
   logic               r_mode;
   logic [4:0]         r_img;
   logic [3:0]         r_cls;
   logic [3:0]         r_feat;
   logic               r_wr;
   logic signed [19:0] r_acc;
   logic signed [19:0] r_best;
   logic [3:0]         r_best_cls;
   logic [3:0]         r_result [32];
   logic               r_done;
   logic [6:0]         r_leds;

   logic signed [19:0] w_dot;
   logic signed [19:0] w_score;
   logic               w_cls_done;

   function automatic logic [3:0] mod10(input logic [4:0] n);
      if (n >= 5'd30)      return 4'(n - 5'd30);
      else if (n >= 5'd20) return 4'(n - 5'd20);
      else if (n >= 5'd10) return 4'(n - 5'd10);
      else                 return n[3:0];
   endfunction

   // Image ROM: a 64 spike at feature (n mod 10), small ramp elsewhere.
   function automatic logic signed [7:0] feature(input logic [4:0] n, input logic [3:0] k);
      logic [2:0] ramp;
      ramp = n[2:0] + k[2:0];
      if (k == mod10(n)) return 8'sd64;
      else               return {5'b0, ramp};
   endfunction

   function automatic logic signed [19:0] mac(input logic [4:0] n, input logic [3:0] c,
                                              input logic [3:0] k);
      logic signed [7:0]  f;
      logic signed [7:0]  w;
      logic signed [19:0] fe;
      logic signed [19:0] we;
      f  = feature(n, k);
      w  = (c == k) ? 8'sd2 : -8'sd1;
      fe = {{12{f[7]}}, f};
      we = {{12{w[7]}}, w};
      return fe * we;
   endfunction

   always_comb begin
      w_dot = '0;
      for (int k = 0; k < 10; k++) w_dot = w_dot + mac(r_img, r_cls, 4'(k));
   end

   assign w_score    = r_mode ? w_dot : (r_acc + mac(r_img, r_cls, r_feat));
   assign w_cls_done = r_mode | (r_feat == 4'd9);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   w_state_nxt = S_RUN;
         S_RUN:    if (r_wr && (r_img == 5'd31)) w_state_nxt = S_FINISH;
         S_FINISH: w_state_nxt = S_FINISH;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode     <= 1'b0;
         r_img      <= '0;
         r_cls      <= '0;
         r_feat     <= '0;
         r_wr       <= 1'b0;
         r_acc      <= '0;
         r_best     <= '0;
         r_best_cls <= '0;
         for (int i = 0; i < 32; i++) r_result[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_mode <= pipeline;
               r_img  <= '0;
               r_cls  <= '0;
               r_feat <= '0;
               r_wr   <= 1'b0;
               r_acc  <= '0;
            end
            S_RUN: begin
               if (r_wr) begin
                  r_result[r_img] <= r_best_cls;
                  r_wr            <= 1'b0;
                  r_img           <= r_img + 5'd1;
                  r_cls           <= '0;
               end else if (w_cls_done) begin
                  // Strict compare keeps the lowest class on ties.
                  if ((r_cls == 4'd0) || (w_score > r_best)) begin
                     r_best     <= w_score;
                     r_best_cls <= r_cls;
                  end
                  r_acc  <= '0;
                  r_feat <= '0;
                  if (r_cls == 4'd9) r_wr  <= 1'b1;
                  else               r_cls <= r_cls + 4'd1;
               end else begin
                  r_acc  <= w_score;
                  r_feat <= r_feat + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_done <= 1'b0;
         r_leds <= 7'h0F;
      end else begin
         r_done <= (w_state_nxt == S_FINISH);
         if (r_done && (switches[6:5] == 2'b01)) r_leds <= {3'b000, r_result[switches[4:0]]};
         else                                    r_leds <= 7'h0F;
      end
   end

   assign leds = r_leds;
   assign done = r_done;

endmodule

// File: tb/tb_top_soc_module.sv
module tb_top_soc_module;

   logic       clk;
   logic       rst;
   logic       pipeline;
   logic [6:0] switches;
   logic [6:0] leds;
   logic       done;

   int         n_tests;
   int         n_fail;
   logic [6:0] exp_q [$];

   top_soc_module dut (
      .clk      (clk),
      .rst      (rst),
      .pipeline (pipeline),
      .switches (switches),
      .leds     (leds),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference classifier straight from the ROM formulas.
   function automatic int ref_class(input int n);
      int best_s, best_c, s, f, w;
      best_s = 0;
      best_c = 0;
      for (int c = 0; c < 10; c++) begin
         s = 0;
         for (int k = 0; k < 10; k++) begin
            f = (k == n % 10) ? 64 : (n + k) % 8;
            w = (c == k) ? 2 : -1;
            s += f * w;
         end
         if (c == 0 || s > best_s) begin
            best_s = s;
            best_c = c;
         end
      end
      return best_c;
   endfunction

   function automatic logic [6:0] ref_leds(input logic [6:0] sw, input logic dn);
      if (dn && sw[6:5] == 2'b01) return 7'(ref_class(int'(sw[4:0])));
      return 7'h0F;
   endfunction

   task automatic drive_sw(input logic [6:0] v, input logic [6:0] e);
      @(negedge clk);
      switches = v;
      exp_q.push_back(e);
   endtask

   task automatic do_reset(input logic mode);
      @(negedge clk);
      rst      = 1'b1;
      pipeline = mode;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [6:0] e;
      rst      = 1'b1;
      pipeline = 1'b1;
      switches = 7'h20;
      repeat (3) @(negedge clk);
      e = 7'h0F;
      n_tests++;
      if (leds !== e) begin
         $display("FAIL reset_leds got=%h exp=%h", leds, e);
         n_fail++;
      end
      n_tests++;
      if (done !== 1'b0) begin
         $display("FAIL reset_done got=%b exp=0", done);
         n_fail++;
      end
      rst = 1'b0;
   endtask

   task automatic test_run(input logic mode, input int lo, input int hi);
      int         cyc;
      logic [6:0] e;
      logic [6:0] seq [6];
      if (rst === 1'b0 && cyc == 0) do_reset(mode);
      // Released from reset at a negedge: count rising edges until done.
      cyc = 0;
      pipeline = mode;
      drive_sw(7'h25, 7'h0F);
      cyc = 1;
      @(negedge clk);
      cyc++;
      e = exp_q.pop_front();
      n_tests++;
      if (leds !== e) begin
         $display("FAIL before_done_mode%0d got=%h exp=%h", mode, leds, e);
         n_fail++;
      end
      while (done !== 1'b1 && cyc < 4000) begin
         @(posedge clk);
         cyc++;
         #1;
      end
      n_tests++;
      if (done !== 1'b1 || cyc > hi || cyc < lo) begin
         $display("FAIL done_timing_mode%0d cycles=%0d done=%b exp=%0d..%0d", mode, cyc, done, lo, hi);
         n_fail++;
      end
      seq[0] = 7'h20; seq[1] = 7'h25; seq[2] = 7'h29;
      seq[3] = 7'h2D; seq[4] = 7'h31; seq[5] = 7'h35;
      for (int i = 0; i < 6; i++) begin
         drive_sw(seq[i], ref_leds(seq[i], 1'b1));
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if (leds !== e) begin
            $display("FAIL seq_mode%0d sw=%h got=%h exp=%h", mode, seq[i], leds, e);
            n_fail++;
         end
      end
   endtask

   task automatic test_locked();
      logic [6:0] e;
      logic [6:0] sws [4];
      sws[0] = 7'h05; sws[1] = 7'h45; sws[2] = 7'h65; sws[3] = 7'h25;
      for (int i = 0; i < 4; i++) begin
         drive_sw(sws[i], ref_leds(sws[i], 1'b1));
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if (leds !== e) begin
            $display("FAIL locked sw=%h got=%h exp=%h", sws[i], leds, e);
            n_fail++;
         end
      end
   endtask

   task automatic test_abort_rerun();
      int         cyc;
      logic [6:0] e;
      do_reset(1'b1);
      switches = 7'h23;
      repeat (100) @(negedge clk);
      rst = 1'b1;
      #1;
      n_tests++;
      if (done !== 1'b0 || leds !== 7'h0F) begin
         $display("FAIL abort_in_reset done=%b leds=%h exp done=0 leds=0f", done, leds);
         n_fail++;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 400) begin
         @(posedge clk);
         cyc++;
         #1;
      end
      n_tests++;
      if (done !== 1'b1 || cyc > 360) begin
         $display("FAIL rerun_done cycles=%0d done=%b exp<=360", cyc, done);
         n_fail++;
      end
      for (int n = 0; n < 32; n++) begin
         drive_sw(7'h20 | 7'(n), 7'(n % 10));
         @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if (leds !== e) begin
            $display("FAIL sweep idx=%0d got=%h exp=%h", n, leds, e);
            n_fail++;
         end
      end
   endtask

   task automatic test_pipeline_toggle();
      logic [6:0] e;
      for (int i = 0; i < 4; i++) begin
         pipeline = ~pipeline;
         drive_sw(7'h20 | 7'(i * 7), ref_leds(7'h20 | 7'(i * 7), 1'b1));
         repeat (3) @(negedge clk);
         e = exp_q.pop_front();
         n_tests++;
         if (leds !== e || done !== 1'b1) begin
            $display("FAIL toggle idx=%0d got=%h done=%b exp=%h done=1", i * 7, leds, done, e);
            n_fail++;
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_run(1'b1, 1, 360);
      test_locked();
      do_reset(1'b0);
      test_run(1'b0, 3000, 3300);
      test_locked();
      test_abort_rerun();
      test_pipeline_toggle();
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/top_soc_module.md
TOP_SOC_MODULE -- requirements
Module: top_soc_module

Interface
REQ-001 Port list (name direction width meaning); single clock; reset asynchronous, active-high.
REQ-002 clk  input  1  system clock, rising-edge.
REQ-003 rst  input  1  asynchronous active-high reset of all state.
REQ-004 pipeline  input  1  engine mode: 1 = parallel MAC per cycle, 0 = sequential one feature per cycle.
REQ-005 switches  input  7  [6:5] = access mode, [4:0] = image index 0..31.
REQ-006 leds  output  7  displayed class ID: 0..9 = CIFAR-10 class, 7'h0F = LOCKED.
REQ-007 done  output  1  high once all 32 stored images are classified; stays high until reset.

Function
REQ-008 Image ROM SHALL hold 32 images × 10 signed 8-bit features: f[n][k] = 64 if k == n mod 10, else (n+k) mod 8.
REQ-009 Weight ROM SHALL hold 10 classes × 10 signed 8-bit weights: w[c][k] = +2 if c == k, else −1.
REQ-010 Score s[n][c] = Σk f[n][k]·w[c][k] in a signed 20-bit accumulator; no saturation needed.
REQ-011 Predicted class of image n = argmax over c of s[n][c]; ties resolve to the lowest c; result is 4 bits.
REQ-012 Results SHALL be stored in a 32-entry × 4-bit result register file indexed by image number.
REQ-013 FSM states: IDLE, RUN, FINISH; IDLE -> RUN on the first clock after rst deasserts.
REQ-014 In RUN, images are processed in order 0..31; RUN -> FINISH after image 31 is written; FINISH is terminal until reset.
REQ-015 pipeline is sampled on IDLE -> RUN; changes during RUN or FINISH are ignored.
REQ-016 pipeline = 1: one (image, class) score per cycle, plus 1 argmax/write cycle per image; 11 cycles per image; done by cycle 360 after reset release.
REQ-017 pipeline = 0: one feature MAC per cycle; 10 cycles per class, plus 1 write cycle per image; done by cycle 3300 after reset release.
REQ-018 Both pipeline modes SHALL produce identical results; expected class of image n = n mod 10.
REQ-019 done is registered and rises on the clock edge that enters FINISH.
REQ-020 leds is registered and updates on every rising edge:
- done = 1 and switches[6:5] = 2'b01: leds = {3'b000, result[switches[4:0]]}.
- Any other case: leds = 7'h0F.
REQ-021 A switches change SHALL be reflected on leds at the first rising edge after the change (1-cycle latency).
REQ-022 Modes 2'b00, 2'b10 and 2'b11 are privacy-locked and SHALL never expose result data.

Reset
REQ-023 While rst = 1: leds = 7'h0F, done = 0, FSM = IDLE, counters = 0, accumulators = 0, result file cleared to 0.
REQ-024 rst asserted mid-RUN SHALL abort immediately; after release, classification restarts from image 0.

Verification
REQ-025 Reset, pipeline = 1, switches = 7'h20, wait done; then switches = 7'h25, 7'h29, 7'h2D, 7'h31, 7'h35 one cycle apart -> leds = 5, 9, 3, 7, 1; done within 360 cycles.
REQ-026 Same sequence with pipeline = 0 -> identical leds values; done within 3300 cycles and not before cycle 3000.
REQ-027 switches = 7'h05 / 7'h45 / 7'h65 after done -> leds = 7'h0F (locked modes).
REQ-028 switches = 7'h25 before done -> leds = 7'h0F; after done -> leds = 7'h05.
REQ-029 Assert rst at cycle 100 of RUN, release -> done = 0 and leds = 7'h0F during reset; full rerun gives correct classes for all indices 0..31 (n mod 10).
REQ-030 Sweep index 0..31 in mode 01 -> leds = n mod 10 for every n; toggle pipeline after done -> no change.
